board_writer: RTL and testbench

//  Write side of the 4x4 board RAM. The game checker reads this RAM one row per

---
 rtl/board_writer_pkg.sv | 43 ++++
 rtl/board_writer_if.sv | 25 ++
 rtl/board_writer_row_merge.sv | 22 ++
 rtl/board_writer.sv | 117 +++++++++++
 tb/tb_board_writer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/board_writer_pkg.sv
// Shared board constants, opcode/state encodings and cursor helpers for the 4x4 board RAM.
package board_writer_pkg;

    localparam int N        = 4;
    localparam int DIG_W    = 4;
    localparam int ADDR_W   = 2;
    localparam int WORD_W   = 24;
    localparam int LOCK_LSB = 16;

    typedef logic [ADDR_W-1:0] pos_t;
    typedef logic [DIG_W-1:0]  digit_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_UP    = 3'd1,
        OP_DOWN  = 3'd2,
        OP_LEFT  = 3'd3,
        OP_RIGHT = 3'd4,
        OP_SET   = 3'd5,
        OP_CLEAR = 3'd6,
        OP_NOP7  = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Cursor moves wrap around the board edge in both directions.
    function automatic pos_t pos_step(input pos_t p, input logic inc);
        if (inc)
            return (p == pos_t'(N-1)) ? '0 : p + 1'b1;
        else
            return (p == '0) ? pos_t'(N-1) : p - 1'b1;
    endfunction

    function automatic logic digit_ok(input digit_t d);
        return (d != '0) && (d <= digit_t'(N));
    endfunction

endpackage

// File: rtl/board_writer_if.sv
// Command handshake and board RAM port bundle between a command source, board_writer and the RAM.
interface board_writer_if;
    import board_writer_pkg::*;

    logic   CmdValid;
    logic   CmdReady;
    logic   [2:0] CmdOp;
    digit_t CmdDigit;
    pos_t   RamAddr;
    word_t  RamRdDat;
    word_t  RamWrDat;
    logic   RamWe;
    logic   EditActive;

    modport slave (
        input  CmdValid, CmdOp, CmdDigit, RamRdDat,
        output CmdReady, RamAddr, RamWrDat, RamWe, EditActive
    );

    modport master (
        output CmdValid, CmdOp, CmdDigit, RamRdDat,
        input  CmdReady, RamAddr, RamWrDat, RamWe, EditActive
    );

endinterface

// File: rtl/board_writer_row_merge.sv
// Combinational cell replace within one row word; reports the cell's lock bit.
// Reserved and lock bits pass through untouched so a loader can reuse it.
module row_merge
    import board_writer_pkg::*;
(
    input  word_t  word_i,
    input  pos_t   col_i,
    input  digit_t digit_i,
    output word_t  word_o,
    output logic   locked_o
);

    int base;

    always_comb begin
        base     = int'(col_i) * DIG_W;
        word_o   = word_i;
        word_o[base +: DIG_W] = digit_i;
        locked_o = word_i[LOCK_LSB + int'(col_i)];
    end

endmodule

// File: rtl/board_writer.sv
// Cursor + single-cell editor for the board RAM; edits are a 2-cycle read-modify-write.
// CmdReady drops for the READ and WRITE cycles, so a held command is taken once per idle cycle.
module board_writer
    import board_writer_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    board_writer_if.slave bus,
    output pos_t CursorRow,
    output pos_t CursorCol,
    output logic DigitErr,
    output logic LockErr
);

    state_e state_q, state_d;
    pos_t   cur_row_q, cur_row_d;
    pos_t   cur_col_q, cur_col_d;
    pos_t   edit_row_q, edit_row_d;
    pos_t   edit_col_q, edit_col_d;
    digit_t edit_dig_q, edit_dig_d;
    logic   derr_q, derr_d;

    word_t  merged_word;
    logic   cell_locked;
    logic   accept;

    row_merge u_row_merge (
        .word_i   (bus.RamRdDat),
        .col_i    (edit_col_q),
        .digit_i  (edit_dig_q),
        .word_o   (merged_word),
        .locked_o (cell_locked)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            edit_row_q <= '0;
            edit_col_q <= '0;
            edit_dig_q <= '0;
            derr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            edit_row_q <= edit_row_d;
            edit_col_q <= edit_col_d;
            edit_dig_q <= edit_dig_d;
            derr_q     <= derr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        edit_row_d = edit_row_q;
        edit_col_d = edit_col_q;
        edit_dig_d = edit_dig_q;
        derr_d     = 1'b0;

        bus.CmdReady   = (state_q == ST_IDLE) && RST_N;
        bus.EditActive = (state_q != ST_IDLE);
        bus.RamAddr    = (state_q == ST_IDLE) ? cur_row_q : edit_row_q;
        bus.RamWe      = 1'b0;
        bus.RamWrDat   = '0;
        LockErr        = 1'b0;

        accept = bus.CmdValid && bus.CmdReady;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op_e'(bus.CmdOp))
                        OP_UP:    cur_row_d = pos_step(cur_row_q, 1'b0);
                        OP_DOWN:  cur_row_d = pos_step(cur_row_q, 1'b1);
                        OP_LEFT:  cur_col_d = pos_step(cur_col_q, 1'b0);
                        OP_RIGHT: cur_col_d = pos_step(cur_col_q, 1'b1);
                        OP_SET: begin
                            if (digit_ok(bus.CmdDigit)) begin
                                edit_row_d = cur_row_q;
                                edit_col_d = cur_col_q;
                                edit_dig_d = bus.CmdDigit;
                                state_d    = ST_READ;
                            end else begin
                                derr_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            edit_row_d = cur_row_q;
                            edit_col_d = cur_col_q;
                            edit_dig_d = '0;
                            state_d    = ST_READ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_READ: state_d = ST_WRITE;
            ST_WRITE: begin
                // Gate on RST_N so a reset landing on the write edge leaves the RAM alone.
                bus.RamWe    = !cell_locked && RST_N;
                bus.RamWrDat = merged_word;
                LockErr      = cell_locked && RST_N;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign CursorRow = cur_row_q;
    assign CursorCol = cur_col_q;
    assign DigitErr  = derr_q;

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: RAM model, expected-event scoreboard and a negedge monitor.
module tb_board_writer;
    import board_writer_pkg::*;

    localparam int K_WR = 0;
    localparam int K_LK = 1;
    localparam int K_DG = 2;

    typedef struct {
        int          kind;
        logic [1:0]  addr;
        logic [23:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pos_t cursor_row, cursor_col;
    logic digit_err, lock_err;

    board_writer_if bif();

    board_writer u_dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .bus       (bif),
        .CursorRow (cursor_row),
        .CursorCol (cursor_col),
        .DigitErr  (digit_err),
        .LockErr   (lock_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    ev_t  exp_q[$];
    logic [23:0] ram [4];

    // RAM model: registered read, write on the strobe edge.
    always @(posedge clk) begin
        bif.RamRdDat <= ram[bif.RamAddr];
        if (bif.RamWe) ram[bif.RamAddr] <= bif.RamWrDat;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [1:0] addr, input logic [23:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe or error pulse must match the next expected event.
    ev_t mon_e;
    int  mon_kind;
    always @(negedge clk) begin
        if (bif.CmdValid && bif.CmdReady) acc_cnt++;
        if (bif.RamWe || lock_err || digit_err) begin
            mon_kind = bif.RamWe ? K_WR : (lock_err ? K_LK : K_DG);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none at %0t",
                         mon_kind, bif.RamAddr, bif.RamWrDat, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", mon_kind, mon_e.kind);
                check("event_onehot", $countones({bif.RamWe, lock_err, digit_err}), 1);
                if (mon_e.kind == K_WR) begin
                    check("wr_addr", bif.RamAddr, mon_e.addr);
                    check("wr_data", bif.RamWrDat, mon_e.data);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] dig);
        int n;
        n = 0;
        bif.CmdValid = 1'b1;
        bif.CmdOp    = op;
        bif.CmdDigit = dig;
        while (!bif.CmdReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bif.CmdReady) check("cmd_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bif.CmdValid = 1'b0;
        bif.CmdOp    = 3'd0;
        bif.CmdDigit = 4'd0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int acc0;

    initial begin
        ram[0] = 24'h011324;
        ram[1] = 24'h001204;
        ram[2] = 24'h000000;
        ram[3] = 24'h000000;
        bif.CmdValid = 1'b0;
        bif.CmdOp    = 3'd0;
        bif.CmdDigit = 4'd0;
        bif.RamRdDat = '0;

        // 1: reset
        cyc(3);
        check("ready_in_reset", bif.CmdReady, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", bif.CmdReady, 1);
        check("row_after_reset", cursor_row, 0);
        check("col_after_reset", cursor_col, 0);
        check("addr_after_reset", bif.RamAddr, 0);
        check("wrdat_after_reset", bif.RamWrDat, 0);
        check("active_after_reset", bif.EditActive, 0);
        cyc(3);

        // 2: wrapping moves
        send(OP_LEFT, 0);
        check("left_wrap_col", cursor_col, 3);
        check("left_wrap_row", cursor_row, 0);
        check("move_no_ram", bif.EditActive, 0);
        send(OP_UP, 0);
        check("up_wrap_row", cursor_row, 3);
        check("up_wrap_col", cursor_col, 3);
        send(OP_RIGHT, 0);
        check("right_wrap_col", cursor_col, 0);
        send(OP_LEFT, 0);
        send(OP_DOWN, 0);
        check("down_wrap_row", cursor_row, 0);

        // 3: SET 3 at (1,2)
        send(OP_DOWN, 0);
        send(OP_LEFT, 0);
        check("pos3_row", cursor_row, 1);
        check("pos3_col", cursor_col, 2);
        push(K_WR, 2'd1, 24'h001304);
        send(OP_SET, 4'd3);
        check("read_addr", bif.RamAddr, 1);
        check("read_active", bif.EditActive, 1);
        check("read_ready", bif.CmdReady, 0);
        cyc(1);
        check("write_we", bif.RamWe, 1);
        check("write_ready", bif.CmdReady, 0);
        cyc(1);
        check("ready_2_after", bif.CmdReady, 1);

        // 4: locked cell, clear, overwrite, same-digit rewrite
        send(OP_UP, 0);
        send(OP_LEFT, 0);
        send(OP_LEFT, 0);
        push(K_LK, 2'd0, 24'h0);
        send(OP_SET, 4'd2);
        cyc(2);
        send(OP_RIGHT, 0);
        push(K_WR, 2'd0, 24'h011304);
        send(OP_CLEAR, 0);
        push(K_WR, 2'd0, 24'h011344);
        send(OP_SET, 4'd4);
        push(K_WR, 2'd0, 24'h011344);
        send(OP_SET, 4'd4);
        cyc(2);

        // 5: illegal digits and NOPs
        push(K_DG, 2'd0, 24'h0);
        send(OP_SET, 4'd0);
        check("set0_idle", bif.EditActive, 0);
        check("set0_ready", bif.CmdReady, 1);
        push(K_DG, 2'd0, 24'h0);
        send(OP_SET, 4'd5);
        check("set5_idle", bif.EditActive, 0);
        send(OP_NOP, 0);
        send(OP_NOP7, 0);
        check("nop_row", cursor_row, 0);
        check("nop_col", cursor_col, 1);
        cyc(1);

        // 6a: valid held across busy cycles
        acc0 = acc_cnt;
        push(K_WR, 2'd0, 24'h011314);
        push(K_WR, 2'd0, 24'h011314);
        bif.CmdValid = 1'b1;
        bif.CmdOp    = OP_SET;
        bif.CmdDigit = 4'd1;
        cyc(6);
        bif.CmdValid = 1'b0;
        check("held_accepts", acc_cnt - acc0, 2);
        cyc(2);

        // 6b: reset during READ aborts the edit
        send(OP_SET, 4'd2);
        check("abort_in_read", bif.EditActive, 1);
        rst_n = 1'b0;
        #1;
        check("ready_low_in_rst", bif.CmdReady, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort_ready", bif.CmdReady, 1);
        check("abort_row", cursor_row, 0);
        check("abort_col", cursor_col, 0);
        check("abort_active", bif.EditActive, 0);
        cyc(4);
        check("abort_ram_kept", ram[0], 24'h011314);
        check("events_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
